// File: rtl/alu_pkg.sv
// Shared types, defaults and operand-need lookup for the alu_dut_core slice.
package alu_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_CWIDTH      = 4;
    localparam int DEF_WAIT_CYCLES = 16;

    typedef enum logic [3:0] {
        A_ADD     = 4'd0,
        A_SUB     = 4'd1,
        A_ADD_CIN = 4'd2,
        A_SUB_CIN = 4'd3,
        A_INC_A   = 4'd4,
        A_DEC_A   = 4'd5,
        A_INC_B   = 4'd6,
        A_DEC_B   = 4'd7,
        A_CMP     = 4'd8
    } arith_cmd_e;

    typedef enum logic [3:0] {
        L_AND     = 4'd0,
        L_NAND    = 4'd1,
        L_OR      = 4'd2,
        L_NOR     = 4'd3,
        L_XOR     = 4'd4,
        L_XNOR    = 4'd5,
        L_NOT_A   = 4'd6,
        L_NOT_B   = 4'd7,
        L_SHR1_A  = 4'd8,
        L_SHL1_A  = 4'd9,
        L_SHR1_B  = 4'd10,
        L_SHL1_B  = 4'd11,
        L_ROL_A_B = 4'd12,
        L_ROR_A_B = 4'd13
    } logic_cmd_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_OP = 2'd1,
        EXEC    = 2'd2
    } state_e;

    localparam logic [1:0] NEED_NONE = 2'b00;
    localparam logic [1:0] NEED_A    = 2'b01;
    localparam logic [1:0] NEED_B    = 2'b10;
    localparam logic [1:0] NEED_AB   = 2'b11;

    // Unknown codes need nothing, so any valid operand lets them through to raise ERR.
    function automatic logic [1:0] op_need(input logic mode, input logic [DEF_CWIDTH-1:0] cmd);
        op_need = NEED_NONE;
        if (mode) begin
            case (cmd)
                A_ADD, A_SUB, A_ADD_CIN, A_SUB_CIN, A_CMP: op_need = NEED_AB;
                A_INC_A, A_DEC_A:                          op_need = NEED_A;
                A_INC_B, A_DEC_B:                          op_need = NEED_B;
                default:                                   op_need = NEED_NONE;
            endcase
        end else begin
            case (cmd)
                L_AND, L_NAND, L_OR, L_NOR, L_XOR, L_XNOR,
                L_ROL_A_B, L_ROR_A_B:                      op_need = NEED_AB;
                L_NOT_A, L_SHR1_A, L_SHL1_A:               op_need = NEED_A;
                L_NOT_B, L_SHR1_B, L_SHL1_B:               op_need = NEED_B;
                default:                                   op_need = NEED_NONE;
            endcase
        end
    endfunction

endpackage

// File: rtl/alu_exec.sv
// Combinational compute unit: one command on held or live operands gives result and flags.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CWIDTH = DEF_CWIDTH
) (
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    input  logic [CWIDTH-1:0] i_cmd,
    input  logic              i_mode,
    input  logic              i_cin,
    output logic [WIDTH+1:0]  o_res,
    output logic              o_cout,
    output logic              o_oflow,
    output logic              o_e,
    output logic              o_g,
    output logic              o_l,
    output logic              o_err
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0]   w_t;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [SW-1:0]    w_amt;
    logic             w_rot_bad;

    assign w_amt     = i_b[SW-1:0];
    // Bit SW of OPB is tolerated; only bits above it flag a bad rotate amount.
    assign w_rot_bad = |(i_b >> (SW + 1));

    always_comb begin
        w_rol = '0;
        w_ror = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_rol[i] = i_a[SW'(i) - w_amt];
            w_ror[i] = i_a[SW'(i) + w_amt];
        end
    end

    always_comb begin
        o_res   = '0;
        o_cout  = 1'b0;
        o_oflow = 1'b0;
        o_e     = 1'b0;
        o_g     = 1'b0;
        o_l     = 1'b0;
        o_err   = 1'b0;
        w_t     = '0;
        if (i_mode) begin
            case (i_cmd)
                A_ADD:     begin w_t = {1'b0, i_a} + {1'b0, i_b};                          o_res = {1'b0, w_t}; o_cout = w_t[WIDTH]; end
                A_ADD_CIN: begin w_t = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin}; o_res = {1'b0, w_t}; o_cout = w_t[WIDTH]; end
                A_INC_A:   begin w_t = {1'b0, i_a} + ONE;                                  o_res = {1'b0, w_t}; o_cout = w_t[WIDTH]; end
                A_INC_B:   begin w_t = {1'b0, i_b} + ONE;                                  o_res = {1'b0, w_t}; o_cout = w_t[WIDTH]; end
                // Subtracting in WIDTH+1 bits leaves the borrow in the top bit.
                A_SUB:     begin w_t = {1'b0, i_a} - {1'b0, i_b};                          o_res = {2'b00, w_t[WIDTH-1:0]}; o_oflow = w_t[WIDTH]; end
                A_SUB_CIN: begin w_t = {1'b0, i_a} - {1'b0, i_b} - {{WIDTH{1'b0}}, i_cin}; o_res = {2'b00, w_t[WIDTH-1:0]}; o_oflow = w_t[WIDTH]; end
                A_DEC_A:   begin w_t = {1'b0, i_a} - ONE;                                  o_res = {2'b00, w_t[WIDTH-1:0]}; o_oflow = w_t[WIDTH]; end
                A_DEC_B:   begin w_t = {1'b0, i_b} - ONE;                                  o_res = {2'b00, w_t[WIDTH-1:0]}; o_oflow = w_t[WIDTH]; end
                A_CMP: begin
                    o_e = (i_a == i_b);
                    o_g = (i_a > i_b);
                    o_l = (i_a < i_b);
                end
                default: o_err = 1'b1;
            endcase
        end else begin
            case (i_cmd)
                L_AND:     o_res = {2'b00, i_a & i_b};
                L_NAND:    o_res = {2'b00, ~(i_a & i_b)};
                L_OR:      o_res = {2'b00, i_a | i_b};
                L_NOR:     o_res = {2'b00, ~(i_a | i_b)};
                L_XOR:     o_res = {2'b00, i_a ^ i_b};
                L_XNOR:    o_res = {2'b00, ~(i_a ^ i_b)};
                L_NOT_A:   o_res = {2'b00, ~i_a};
                L_NOT_B:   o_res = {2'b00, ~i_b};
                L_SHR1_A:  o_res = {2'b00, i_a >> 1};
                L_SHL1_A:  o_res = {2'b00, i_a << 1};
                L_SHR1_B:  o_res = {2'b00, i_b >> 1};
                L_SHL1_B:  o_res = {2'b00, i_b << 1};
                L_ROL_A_B: if (w_rot_bad) o_err = 1'b1; else o_res = {2'b00, w_rol};
                L_ROR_A_B: if (w_rot_bad) o_err = 1'b1; else o_res = {2'b00, w_ror};
                default:   o_err = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/alu_dut_core.sv
// ALU core: operand collection FSM, wait counter and registered outputs.
// Build option: define ALU_WAIT_EN to hold a lone operand and wait for its partner.
module alu_dut_core
    import alu_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int CWIDTH      = DEF_CWIDTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    localparam int CNT_W      = $clog2(WAIT_CYCLES + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  OPA,
    input  logic [WIDTH-1:0]  OPB,
    input  logic [CWIDTH-1:0] CMD,
    input  logic              MODE,
    input  logic              CIN,
    input  logic              CE,
    input  logic [1:0]        INP_VALID,
    output logic [WIDTH+1:0]  RES,
    output logic              COUT,
    output logic              OFLOW,
    output logic              E,
    output logic              G,
    output logic              L,
    output logic              ERR,
    output state_e            o_dbg_state,
    output logic [CNT_W-1:0]  o_dbg_cnt
);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [CWIDTH-1:0]  r_cmd;
    logic               r_mode, r_cin;
    logic [1:0]         r_have;
    logic [WIDTH+1:0]   r_res;
    logic               r_cout, r_oflow, r_e, r_g, r_l, r_err;

    state_e             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_in_wait, w_load, w_force_err, w_latch_ctl, w_latch_ops;
    logic [CWIDTH-1:0]  w_cmd;
    logic               w_mode, w_cin;
    logic [WIDTH-1:0]   w_a, w_b;
    logic [1:0]         w_need;
    logic [WIDTH+1:0]   w_res;
    logic               w_cout, w_oflow, w_e, w_g, w_l, w_err;

    // While waiting, the held command wins and the held operand fills the missing slot.
    assign w_in_wait = (r_state == WAIT_OP);
    assign w_cmd     = w_in_wait ? r_cmd  : CMD;
    assign w_mode    = w_in_wait ? r_mode : MODE;
    assign w_cin     = w_in_wait ? r_cin  : CIN;
    assign w_a       = (w_in_wait && !INP_VALID[0]) ? r_a : OPA;
    assign w_b       = (w_in_wait && !INP_VALID[1]) ? r_b : OPB;
    assign w_need    = op_need(w_mode, w_cmd);

    alu_exec #(.WIDTH(WIDTH), .CWIDTH(CWIDTH)) u_exec (
        .i_a     (w_a),
        .i_b     (w_b),
        .i_cmd   (w_cmd),
        .i_mode  (w_mode),
        .i_cin   (w_cin),
        .o_res   (w_res),
        .o_cout  (w_cout),
        .o_oflow (w_oflow),
        .o_e     (w_e),
        .o_g     (w_g),
        .o_l     (w_l),
        .o_err   (w_err)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_force_err = 1'b0;
        w_latch_ctl = 1'b0;
        w_latch_ops = 1'b0;
        case (r_state)
            WAIT_OP: begin
                if ((INP_VALID & ~r_have) != 2'b00) begin
                    w_load      = 1'b1;
                    w_state_nxt = EXEC;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= CNT_W'(WAIT_CYCLES)) begin
                    w_load      = 1'b1;
                    w_force_err = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_latch_ops = (INP_VALID != 2'b00);
                end
            end
            default: begin
                // EXEC accepts new work exactly like IDLE so results can stream every cycle.
                w_cnt_nxt = '0;
                if (INP_VALID == 2'b00) begin
                    w_state_nxt = IDLE;
                end else if ((w_need & ~INP_VALID) == 2'b00) begin
                    w_load      = 1'b1;
                    w_state_nxt = EXEC;
                end else if (w_need == NEED_AB) begin
`ifdef ALU_WAIT_EN
                    w_latch_ctl = 1'b1;
                    w_latch_ops = 1'b1;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = WAIT_OP;
`else
                    w_load      = 1'b1;
                    w_force_err = 1'b1;
                    w_state_nxt = IDLE;
`endif
                end else begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cmd   <= '0;
            r_mode  <= 1'b0;
            r_cin   <= 1'b0;
            r_have  <= 2'b00;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_oflow <= 1'b0;
            r_e     <= 1'b0;
            r_g     <= 1'b0;
            r_l     <= 1'b0;
            r_err   <= 1'b0;
        end else if (CE) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch_ctl) begin
                r_cmd  <= CMD;
                r_mode <= MODE;
                r_cin  <= CIN;
                r_have <= INP_VALID;
            end
            if (w_latch_ops) begin
                if (INP_VALID[0]) r_a <= OPA;
                if (INP_VALID[1]) r_b <= OPB;
            end
            if (w_load) begin
                r_res   <= w_force_err ? '0   : w_res;
                r_cout  <= w_force_err ? 1'b0 : w_cout;
                r_oflow <= w_force_err ? 1'b0 : w_oflow;
                r_e     <= w_force_err ? 1'b0 : w_e;
                r_g     <= w_force_err ? 1'b0 : w_g;
                r_l     <= w_force_err ? 1'b0 : w_l;
                r_err   <= w_force_err ? 1'b1 : w_err;
            end
        end
    end

    assign RES         = r_res;
    assign COUT        = r_cout;
    assign OFLOW       = r_oflow;
    assign E           = r_e;
    assign G           = r_g;
    assign L           = r_l;
    assign ERR         = r_err;
    assign o_dbg_state = r_state;
    assign o_dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_alu_dut_core.sv
// Directed vector bench for alu_dut_core; wait-mode sequences follow ALU_WAIT_EN.
module tb_alu_dut_core;
    import alu_pkg::*;

    localparam int W     = 8;
    localparam int CNT_W = 5;
    localparam int NV    = 34;

    logic             CLK, RST, MODE, CIN, CE;
    logic [W-1:0]     OPA, OPB;
    logic [3:0]       CMD;
    logic [1:0]       INP_VALID;
    logic [W+1:0]     RES;
    logic             COUT, OFLOW, E, G, L, ERR;
    state_e           dbg_state;
    logic [CNT_W-1:0] dbg_cnt;
    logic [15:0]      w_obs;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_exp;

    typedef struct {
        logic        mode;
        logic [3:0]  cmd;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        cin;
        logic [1:0]  v;
        logic [15:0] exp;
    } vec_t;
    vec_t vtab[NV];

    alu_dut_core dut (
        .CLK(CLK), .RST(RST), .OPA(OPA), .OPB(OPB), .CMD(CMD), .MODE(MODE),
        .CIN(CIN), .CE(CE), .INP_VALID(INP_VALID), .RES(RES), .COUT(COUT),
        .OFLOW(OFLOW), .E(E), .G(G), .L(L), .ERR(ERR),
        .o_dbg_state(dbg_state), .o_dbg_cnt(dbg_cnt)
    );

    assign w_obs = {RES, COUT, OFLOW, E, G, L, ERR};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] pk(input logic [9:0] res, input logic cout, input logic oflow,
                                       input logic e, input logic g, input logic l, input logic err);
        return {res, cout, oflow, e, g, l, err};
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got res=%h c/o/e/g/l/err=%b expected res=%h c/o/e/g/l/err=%b",
                     name, act[15:6], act[5:0], exp[15:6], exp[5:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic mode, input logic [3:0] cmd, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic [1:0] v);
        MODE = mode; CMD = cmd; OPA = a; OPB = b; CIN = cin; INP_VALID = v;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vtab[0]  = '{1'b1, 4'd0,  8'hFF, 8'h01, 1'b0, 2'b11, pk(10'h100, 1, 0, 0, 0, 0, 0)};
        vtab[1]  = '{1'b1, 4'd0,  8'h12, 8'h34, 1'b0, 2'b11, pk(10'h046, 0, 0, 0, 0, 0, 0)};
        vtab[2]  = '{1'b1, 4'd0,  8'h01, 8'h01, 1'b1, 2'b11, pk(10'h002, 0, 0, 0, 0, 0, 0)};
        vtab[3]  = '{1'b1, 4'd1,  8'h10, 8'h20, 1'b0, 2'b11, pk(10'h0F0, 0, 1, 0, 0, 0, 0)};
        vtab[4]  = '{1'b1, 4'd1,  8'h20, 8'h10, 1'b0, 2'b11, pk(10'h010, 0, 0, 0, 0, 0, 0)};
        vtab[5]  = '{1'b1, 4'd2,  8'hFF, 8'h00, 1'b1, 2'b11, pk(10'h100, 1, 0, 0, 0, 0, 0)};
        vtab[6]  = '{1'b1, 4'd3,  8'h05, 8'h05, 1'b1, 2'b11, pk(10'h0FF, 0, 1, 0, 0, 0, 0)};
        vtab[7]  = '{1'b1, 4'd3,  8'h06, 8'h05, 1'b1, 2'b11, pk(10'h000, 0, 0, 0, 0, 0, 0)};
        vtab[8]  = '{1'b1, 4'd4,  8'hFF, 8'h00, 1'b0, 2'b01, pk(10'h100, 1, 0, 0, 0, 0, 0)};
        vtab[9]  = '{1'b1, 4'd5,  8'h00, 8'h00, 1'b0, 2'b01, pk(10'h0FF, 0, 1, 0, 0, 0, 0)};
        vtab[10] = '{1'b1, 4'd6,  8'h00, 8'h7F, 1'b0, 2'b10, pk(10'h080, 0, 0, 0, 0, 0, 0)};
        vtab[11] = '{1'b1, 4'd7,  8'h00, 8'h01, 1'b0, 2'b10, pk(10'h000, 0, 0, 0, 0, 0, 0)};
        vtab[12] = '{1'b1, 4'd8,  8'h05, 8'h09, 1'b0, 2'b11, pk(10'h000, 0, 0, 0, 0, 1, 0)};
        vtab[13] = '{1'b1, 4'd8,  8'h33, 8'h33, 1'b0, 2'b11, pk(10'h000, 0, 0, 1, 0, 0, 0)};
        vtab[14] = '{1'b1, 4'd8,  8'h09, 8'h05, 1'b0, 2'b11, pk(10'h000, 0, 0, 0, 1, 0, 0)};
        vtab[15] = '{1'b1, 4'd9,  8'h01, 8'h01, 1'b0, 2'b11, pk(10'h000, 0, 0, 0, 0, 0, 1)};
        vtab[16] = '{1'b0, 4'd0,  8'hF0, 8'h3C, 1'b0, 2'b11, pk(10'h030, 0, 0, 0, 0, 0, 0)};
        vtab[17] = '{1'b0, 4'd1,  8'hF0, 8'h3C, 1'b0, 2'b11, pk(10'h0CF, 0, 0, 0, 0, 0, 0)};
        vtab[18] = '{1'b0, 4'd2,  8'hF0, 8'h0F, 1'b0, 2'b11, pk(10'h0FF, 0, 0, 0, 0, 0, 0)};
        vtab[19] = '{1'b0, 4'd3,  8'hF0, 8'h0F, 1'b0, 2'b11, pk(10'h000, 0, 0, 0, 0, 0, 0)};
        vtab[20] = '{1'b0, 4'd4,  8'hAA, 8'hFF, 1'b0, 2'b11, pk(10'h055, 0, 0, 0, 0, 0, 0)};
        vtab[21] = '{1'b0, 4'd5,  8'hAA, 8'hFF, 1'b0, 2'b11, pk(10'h0AA, 0, 0, 0, 0, 0, 0)};
        vtab[22] = '{1'b0, 4'd6,  8'h0F, 8'h00, 1'b0, 2'b01, pk(10'h0F0, 0, 0, 0, 0, 0, 0)};
        vtab[23] = '{1'b0, 4'd7,  8'h00, 8'h0F, 1'b0, 2'b10, pk(10'h0F0, 0, 0, 0, 0, 0, 0)};
        vtab[24] = '{1'b0, 4'd8,  8'h81, 8'h00, 1'b0, 2'b01, pk(10'h040, 0, 0, 0, 0, 0, 0)};
        vtab[25] = '{1'b0, 4'd9,  8'h81, 8'h00, 1'b0, 2'b01, pk(10'h002, 0, 0, 0, 0, 0, 0)};
        vtab[26] = '{1'b0, 4'd10, 8'h00, 8'h03, 1'b0, 2'b10, pk(10'h001, 0, 0, 0, 0, 0, 0)};
        vtab[27] = '{1'b0, 4'd11, 8'h00, 8'hC0, 1'b0, 2'b10, pk(10'h080, 0, 0, 0, 0, 0, 0)};
        vtab[28] = '{1'b0, 4'd12, 8'h81, 8'h01, 1'b0, 2'b11, pk(10'h003, 0, 0, 0, 0, 0, 0)};
        vtab[29] = '{1'b0, 4'd12, 8'h81, 8'h10, 1'b0, 2'b11, pk(10'h000, 0, 0, 0, 0, 0, 1)};
        vtab[30] = '{1'b0, 4'd13, 8'h81, 8'h01, 1'b0, 2'b11, pk(10'h0C0, 0, 0, 0, 0, 0, 0)};
        vtab[31] = '{1'b0, 4'd12, 8'h81, 8'h08, 1'b0, 2'b11, pk(10'h081, 0, 0, 0, 0, 0, 0)};
        vtab[32] = '{1'b0, 4'd13, 8'h12, 8'h07, 1'b0, 2'b11, pk(10'h024, 0, 0, 0, 0, 0, 0)};
        vtab[33] = '{1'b0, 4'd14, 8'h01, 8'h01, 1'b0, 2'b11, pk(10'h000, 0, 0, 0, 0, 0, 1)};

        // Clock/reset
        RST = 1'b0; CE = 1'b1;
        drive(1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 2'b00);
        tick();
        tick();
        check16("reset_outputs", w_obs, 16'h0000);
        check_int("reset_state", int'(dbg_state), int'(IDLE));
        check_int("reset_cnt", int'(dbg_cnt), 0);
        RST = 1'b1;

        // Back-to-back vectors, one result per cycle
        for (int i = 0; i < NV; i++) begin
            drive(vtab[i].mode, vtab[i].cmd, vtab[i].a, vtab[i].b, vtab[i].cin, vtab[i].v);
            exp_q.push_back(vtab[i].exp);
            tick();
            last_exp = exp_q.pop_front();
            check16($sformatf("vec%0d", i), w_obs, last_exp);
        end

        // No valid operands: outputs hold
        drive(1'b1, 4'd0, 8'h01, 8'h01, 1'b0, 2'b00);
        tick();
        tick();
        check16("hold_idle", w_obs, last_exp);
        check_int("hold_state", int'(dbg_state), int'(IDLE));

        // CE low freezes outputs, then the same inputs execute once CE returns
        CE = 1'b0;
        drive(1'b1, 4'd0, 8'h01, 8'h01, 1'b0, 2'b11);
        tick();
        check16("ce_freeze", w_obs, last_exp);
        CE = 1'b1;
        tick();
        check16("ce_resume", w_obs, pk(10'h002, 0, 0, 0, 0, 0, 0));

        // Reset overrides CE
        CE = 1'b0; RST = 1'b0;
        tick();
        check16("reset_over_ce", w_obs, 16'h0000);
        RST = 1'b1; CE = 1'b1;

`ifdef ALU_WAIT_EN
        // Held SUB survives a different command on the bus
        drive(1'b1, 4'd0, 8'h01, 8'h01, 1'b0, 2'b11);
        tick();
        check16("w_base", w_obs, pk(10'h002, 0, 0, 0, 0, 0, 0));
        drive(1'b1, 4'd1, 8'h10, 8'h00, 1'b0, 2'b01);
        tick();
        check_int("w_latch_state", int'(dbg_state), int'(WAIT_OP));
        check_int("w_latch_cnt", int'(dbg_cnt), 1);
        check16("w_latch_hold", w_obs, pk(10'h002, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'd4, 8'h00, 8'h00, 1'b0, 2'b00);
            tick();
        end
        check_int("w_cnt_after3", int'(dbg_cnt), 4);
        drive(1'b1, 4'd4, 8'h00, 8'h20, 1'b0, 2'b10);
        tick();
        check16("w_sub_result", w_obs, pk(10'h0F0, 0, 1, 0, 0, 0, 0));
        check_int("w_exec_state", int'(dbg_state), int'(EXEC));

        // Timeout boundary
        drive(1'b1, 4'd0, 8'h01, 8'h01, 1'b0, 2'b11);
        tick();
        drive(1'b1, 4'd0, 8'h05, 8'h00, 1'b0, 2'b01);
        tick();
        for (int k = 0; k < 15; k++) begin
            drive(1'b1, 4'd0, 8'h00, 8'h00, 1'b0, 2'b00);
            tick();
        end
        check16("w_pre_timeout", w_obs, pk(10'h002, 0, 0, 0, 0, 0, 0));
        check_int("w_pre_timeout_state", int'(dbg_state), int'(WAIT_OP));
        check_int("w_pre_timeout_cnt", int'(dbg_cnt), 16);
        tick();
        check16("w_timeout_err", w_obs, pk(10'h000, 0, 0, 0, 0, 0, 1));
        check_int("w_timeout_state", int'(dbg_state), int'(IDLE));

        // CE low mid-wait freezes the counter
        drive(1'b1, 4'd0, 8'h03, 8'h00, 1'b0, 2'b01);
        tick();
        drive(1'b1, 4'd0, 8'h00, 8'h00, 1'b0, 2'b00);
        tick();
        CE = 1'b0;
        drive(1'b1, 4'd0, 8'h77, 8'h77, 1'b0, 2'b11);
        for (int k = 0; k < 5; k++) tick();
        check_int("w_ce_cnt", int'(dbg_cnt), 2);
        check_int("w_ce_state", int'(dbg_state), int'(WAIT_OP));
        check16("w_ce_outputs", w_obs, pk(10'h000, 0, 0, 0, 0, 0, 1));
        CE = 1'b1;
        drive(1'b1, 4'd4, 8'h00, 8'h04, 1'b0, 2'b10);
        tick();
        check16("w_ce_complete", w_obs, pk(10'h007, 0, 0, 0, 0, 0, 0));

        // Held operand overwritten while the counter keeps running
        drive(1'b1, 4'd0, 8'h01, 8'h00, 1'b0, 2'b01);
        tick();
        drive(1'b1, 4'd0, 8'h05, 8'h00, 1'b0, 2'b01);
        tick();
        check_int("w_ovw_cnt", int'(dbg_cnt), 2);
        drive(1'b1, 4'd0, 8'h00, 8'h03, 1'b0, 2'b10);
        tick();
        check16("w_ovw_result", w_obs, pk(10'h008, 0, 0, 0, 0, 0, 0));

        // Reset mid-wait, then a fresh partial restarts the counter at 1
        drive(1'b1, 4'd0, 8'h09, 8'h00, 1'b0, 2'b01);
        tick();
        drive(1'b1, 4'd0, 8'h00, 8'h00, 1'b0, 2'b00);
        tick();
        RST = 1'b0;
        tick();
        check16("w_rst_outputs", w_obs, 16'h0000);
        check_int("w_rst_state", int'(dbg_state), int'(IDLE));
        check_int("w_rst_cnt", int'(dbg_cnt), 0);
        RST = 1'b1;
        drive(1'b1, 4'd0, 8'h01, 8'h00, 1'b0, 2'b01);
        tick();
        check_int("w_restart_cnt", int'(dbg_cnt), 1);
        drive(1'b1, 4'd0, 8'h00, 8'h01, 1'b0, 2'b10);
        tick();
        check16("w_restart_result", w_obs, pk(10'h002, 0, 0, 0, 0, 0, 0));
`else
        // Missing operand errors immediately with no latch
        drive(1'b1, 4'd0, 8'h02, 8'h03, 1'b0, 2'b11);
        tick();
        check16("nw_base", w_obs, pk(10'h005, 0, 0, 0, 0, 0, 0));
        drive(1'b1, 4'd1, 8'h10, 8'h00, 1'b0, 2'b01);
        tick();
        check16("nw_missing_err", w_obs, pk(10'h000, 0, 0, 0, 0, 0, 1));
        check_int("nw_state", int'(dbg_state), int'(IDLE));
        check_int("nw_cnt", int'(dbg_cnt), 0);
        drive(1'b0, 4'd4, 8'h00, 8'h20, 1'b0, 2'b10);
        tick();
        check16("nw_missing_b_err", w_obs, pk(10'h000, 0, 0, 0, 0, 0, 1));
        drive(1'b1, 4'd1, 8'h30, 8'h10, 1'b0, 2'b11);
        tick();
        check16("nw_recover", w_obs, pk(10'h020, 0, 0, 0, 0, 0, 0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
